// File: rtl/dmem_resp_pkg.sv
// Shared constants and types for the data-memory responder.
// Request encodings, bus widths, idle values and FSM state encodings.
package dmem_resp_pkg;

    localparam int DATA_BUS = 32;
    localparam int REG_BUS  = 5;
    localparam int CNT_W    = 3;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [REG_BUS-1:0]  REG_X0    = '0;
    localparam logic [DATA_BUS-1:0] DATA_ZERO = '0;

    typedef enum logic {
        DMEM_IDLE    = 1'b0,
        DMEM_RD_WAIT = 1'b1
    } dmem_state_e;

    // Word index relative to the RAM base; the caller range-checks it.
    function automatic logic [DATA_BUS-1:0] word_offset(input logic [DATA_BUS-1:0] addr,
                                                        input logic [DATA_BUS-1:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Execute-stage memory request / writeback response bundle.
// Signal suffixes are from the responder's point of view.
interface dmem_resp_if;
    import dmem_resp_pkg::*;

    logic                req_ena_i;
    logic                req_rw_i;
    logic [DATA_BUS-1:0] req_addr_i;
    logic [DATA_BUS-1:0] req_wdata_i;
    logic [REG_BUS-1:0]  req_gprs_waddr_i;
    logic                busy_o;
    logic                rsp_valid_o;
    logic [REG_BUS-1:0]  rsp_gprs_waddr_o;
    logic [DATA_BUS-1:0] rsp_gprs_wdata_o;
    logic                err_o;
    logic [DATA_BUS-1:0] err_addr_o;

    modport master (
        output req_ena_i, req_rw_i, req_addr_i, req_wdata_i, req_gprs_waddr_i,
        input  busy_o, rsp_valid_o, rsp_gprs_waddr_o, rsp_gprs_wdata_o, err_o, err_addr_o
    );

    modport slave (
        input  req_ena_i, req_rw_i, req_addr_i, req_wdata_i, req_gprs_waddr_i,
        output busy_o, rsp_valid_o, rsp_gprs_waddr_o, rsp_gprs_wdata_o, err_o, err_addr_o
    );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with a one-cycle registered read, write-first.
// Contents and the read register are never reset.
module dmem_ram
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int          IDX_W = 10
) (
    input  logic                clk,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    addr_i,
    input  logic [DATA_BUS-1:0] wdata_i,
    output logic [DATA_BUS-1:0] rdata_o
);

    logic [DATA_BUS-1:0] mem_q [DEPTH];
    logic [DATA_BUS-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: stores go straight to RAM, loads stall the front end
// for RD_LAT cycles and return their data with the destination GPR.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned RD_LAT    = 2,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_resp_if.slave mem_if
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    dmem_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REG_BUS-1:0]  waddr_q, waddr_d;
    logic                fault_q, fault_d;
    logic                err_q, err_d;
    logic [DATA_BUS-1:0] err_addr_q, err_addr_d;

    logic [DATA_BUS-1:0] word_off;
    logic [DATA_BUS-1:0] ram_rdata;
    logic                req_fault;
    logic                req_seen;
    logic                accept_rd;
    logic                accept_wr;
    logic                done;
    logic                ram_en;

    assign word_off  = word_offset(mem_if.req_addr_i, ADDR_BASE);
    assign req_fault = (mem_if.req_addr_i[1:0] != 2'b00) ||
                       (mem_if.req_addr_i < ADDR_BASE)   ||
                       (word_off >= DEPTH);

    // Requests are only looked at in IDLE, so the completion cycle never re-accepts.
    assign req_seen  = (state_q == DMEM_IDLE) && (mem_if.req_ena_i == ENABLE);
    assign accept_rd = req_seen && (mem_if.req_rw_i == MEM_READ);
    assign accept_wr = req_seen && (mem_if.req_rw_i == MEM_WRITE);
    assign done      = (state_q == DMEM_RD_WAIT) && (cnt_q == '0);
    assign ram_en    = (accept_rd || (accept_wr && !req_fault)) ? ENABLE : DISABLE;

    dmem_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (accept_wr),
        .addr_i  (word_off[IDX_W-1:0]),
        .wdata_i (mem_if.req_wdata_i),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        waddr_d    = waddr_q;
        fault_d    = fault_q;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        case (state_q)
            DMEM_IDLE: begin
                if (req_seen) begin
                    err_d = req_fault;
                    if (req_fault) begin
                        err_addr_d = mem_if.req_addr_i;
                    end
                    if (accept_rd) begin
                        state_d = DMEM_RD_WAIT;
                        cnt_d   = CNT_LOAD;
                        waddr_d = mem_if.req_gprs_waddr_i;
                        fault_d = req_fault;
                    end
                end
            end
            DMEM_RD_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DMEM_IDLE;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DMEM_IDLE;
            cnt_q      <= '0;
            waddr_q    <= REG_X0;
            fault_q    <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= DATA_ZERO;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            waddr_q    <= waddr_d;
            fault_q    <= fault_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // The RAM read register holds the load word until the completion cycle.
    assign mem_if.busy_o           = accept_rd || ((state_q == DMEM_RD_WAIT) && (cnt_q != '0));
    assign mem_if.rsp_valid_o      = done;
    assign mem_if.rsp_gprs_waddr_o = done ? waddr_q : REG_X0;
    assign mem_if.rsp_gprs_wdata_o = (done && !fault_q) ? ram_rdata : DATA_ZERO;
    assign mem_if.err_o            = err_q;
    assign mem_if.err_addr_o       = err_addr_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: four responders with RD_LAT 1..4 share one stimulus driver;
// a cycle-accurate transaction model predicts every output each cycle.
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    localparam int unsigned DEPTH_TB = 1024;
    localparam logic [31:0] BASE_TB  = 32'h0000_0000;
    localparam int          LANES    = 4;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  gpr;
    int          sel;

    logic        busy_w   [LANES];
    logic        valid_w  [LANES];
    logic [4:0]  rwaddr_w [LANES];
    logic [31:0] rdata_w  [LANES];
    logic        err_w    [LANES];
    logic [31:0] eaddr_w  [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dmem_resp_if bus ();
        assign bus.req_ena_i        = ena & (sel == g);
        assign bus.req_rw_i         = rw;
        assign bus.req_addr_i       = addr;
        assign bus.req_wdata_i      = wdata;
        assign bus.req_gprs_waddr_i = gpr;
        assign busy_w[g]   = bus.busy_o;
        assign valid_w[g]  = bus.rsp_valid_o;
        assign rwaddr_w[g] = bus.rsp_gprs_waddr_o;
        assign rdata_w[g]  = bus.rsp_gprs_wdata_o;
        assign err_w[g]    = bus.err_o;
        assign eaddr_w[g]  = bus.err_addr_o;

        dmem_resp #(
            .DEPTH     (DEPTH_TB),
            .RD_LAT    (g + 1),
            .ADDR_BASE (BASE_TB)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .mem_if (bus)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_chk;
    int          n_fail;
    int          cyc;
    int          lat;
    bit          pend;
    bit          acc;
    int          pend_done;
    int          free_c;
    int          err_c;
    logic [4:0]  pend_gpr;
    logic [31:0] pend_data;
    logic [31:0] err_addr_m [LANES];
    logic [31:0] mem_m      [LANES][16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (lane %0d cycle %0d)", tag, got, exp, sel, cyc);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE_TB) || (((a - BASE_TB) >> 2) >= DEPTH_TB);
    endfunction

    // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        bit          e_valid;
        bit          e_busy;
        logic [31:0] idx;
        @(negedge clk);
        e_valid = pend && (cyc == pend_done);
        e_busy  = (pend && (cyc < pend_done)) ||
                  (rst_n && ena && (rw == MEM_READ) && (cyc >= free_c));
        chk("busy",       32'(busy_w[sel]),  32'(e_busy));
        chk("rsp_valid",  32'(valid_w[sel]), 32'(e_valid));
        chk("rsp_waddr",  32'(rwaddr_w[sel]), e_valid ? 32'(pend_gpr) : 32'(REG_X0));
        chk("rsp_wdata",  rdata_w[sel],      e_valid ? pend_data : DATA_ZERO);
        chk("err",        32'(err_w[sel]),   32'(cyc == err_c));
        chk("err_addr",   eaddr_w[sel],      err_addr_m[sel]);
        @(posedge clk);
        acc = 1'b0;
        if (rst_n) begin
            if (pend && (cyc == pend_done)) pend = 1'b0;
            if (ena && (cyc >= free_c)) begin
                acc = 1'b1;
                idx = (addr - BASE_TB) >> 2;
                if (is_fault(addr)) begin
                    err_c           = cyc + 1;
                    err_addr_m[sel] = addr;
                end
                if (rw == MEM_WRITE) begin
                    if (!is_fault(addr)) mem_m[sel][idx[3:0]] = wdata;
                end else begin
                    pend      = 1'b1;
                    pend_done = cyc + lat;
                    free_c    = cyc + lat + 1;
                    pend_gpr  = gpr;
                    pend_data = is_fault(addr) ? DATA_ZERO : mem_m[sel][idx[3:0]];
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        ena   = DISABLE;
        rw    = 1'($urandom_range(0, 1));
        addr  = $urandom;
        wdata = $urandom;
        gpr   = 5'($urandom_range(0, 31));
        for (int i = 0; i < n; i++) step();
    endtask

    // Present a request, hold it until accepted and, for a load, through completion.
    task automatic req(input logic rw_v, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] g, input bit wait_done);
        ena   = ENABLE;
        rw    = rw_v;
        addr  = a;
        wdata = d;
        gpr   = g;
        acc   = 1'b0;
        for (int i = 0; i < 16 && !acc; i++) step();
        if (rw_v == MEM_READ && wait_done) begin
            for (int i = 0; i < 16 && pend; i++) step();
        end
    endtask

    task automatic apply_reset(input int n);
        rst_n  = 1'b0;
        ena    = DISABLE;
        pend   = 1'b0;
        free_c = 0;
        err_c  = -1;
        for (int i = 0; i < LANES; i++) err_addr_m[i] = DATA_ZERO;
        for (int i = 0; i < n; i++) step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        sel    = 0;
        lat    = 1;
        rst_n  = 1'b1;
        ena    = DISABLE;
        rw     = MEM_READ;
        addr   = '0;
        wdata  = '0;
        gpr    = '0;
        #1;
        apply_reset(2);
        idle(10);

        for (int l = 0; l < LANES; l++) begin
            sel    = l;
            lat    = l + 1;
            pend   = 1'b0;
            free_c = 0;
            err_c  = -1;
            idle(2);
            for (int w = 0; w < 16; w++) req(MEM_WRITE, 32'(w * 4), $urandom, 5'd0, 1'b1);

            req(MEM_WRITE, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b1);
            req(MEM_READ,  32'h10, 32'h0, 5'd5, 1'b1);
            idle(1);

            req(MEM_READ,  32'h12, 32'h0, 5'd7, 1'b1);
            req(MEM_WRITE, 32'h1000, 32'hBAD0_0BAD, 5'd0, 1'b1);
            idle(1);
            req(MEM_READ,  32'h0, 32'h0, 5'd1, 1'b1);

            req(MEM_READ, 32'h0, 32'h0, 5'd2, 1'b1);
            req(MEM_READ, 32'h4, 32'h0, 5'd3, 1'b1);
            idle(2);

            for (int k = 0; k < 40; k++) begin
                r = $urandom_range(0, 9);
                a = 32'($urandom_range(0, 15)) << 2;
                if (r == 6) a = a | 32'($urandom_range(1, 3));
                if (r == 7) a = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
                if (r == 8) a = 32'hFFFF_FFFC;
                req(1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)), 1'b1);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
            idle(2);

            req(MEM_READ, 32'h8, 32'h0, 5'd9, 1'b0);
            apply_reset(1);
            idle(lat + 3);
            req(MEM_READ, 32'h8, 32'h0, 5'd10, 1'b1);
            idle(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
